// File: rtl/wishbone_master_ctl.sv
// ============================================================================
// Module   : wishbone_master_ctl
// Brief    : Wishbone classic single-access initiator with bus watchdog.
//            Converts one host valid/ready command into one read or write cycle.
//            Returns read data and status on a valid/ready response channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wishbone_master_ctl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    // host command channel
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    // host response channel
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    // wishbone initiator port
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    localparam int TO_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int c_TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    // One-hot so that ready/cyc/valid are taken straight from flop outputs.
    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_BUS  = 3'b010,
        S_RESP = 3'b100
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_we;
    logic [31:0]       r_adr;
    logic [31:0]       r_dat;
    logic [3:0]        r_sel;
    logic [31:0]       r_rsp_dat;
    logic              r_rsp_err;
    logic [TO_W-1:0]   r_cnt;
    logic              w_timeout;

    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_W'(c_TO_LAST));

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (cmd_valid_i) w_state_nxt = S_BUS;
            S_BUS:   if (wbm_ack_i || wbm_err_i || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready_i) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Request fields, response capture and watchdog counter.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_we      <= 1'b0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_we  <= cmd_we_i;
                        r_adr <= cmd_adr_i;
                        r_dat <= cmd_dat_i;
                        r_sel <= cmd_sel_i;
                        r_cnt <= '0;
                    end
                end
                S_BUS: begin
                    if (r_cnt != '1) begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                    // ack wins over err, err wins over the watchdog
                    if (wbm_ack_i) begin
                        r_rsp_dat <= r_we ? 32'h0 : wbm_dat_i;
                        r_rsp_err <= 1'b0;
                    end else if (wbm_err_i || w_timeout) begin
                        r_rsp_dat <= 32'h0;
                        r_rsp_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready_o = r_state[0];
    assign wbm_cyc_o   = r_state[1];
    assign wbm_stb_o   = r_state[1];
    assign rsp_valid_o = r_state[2];
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_err_o   = r_rsp_err;
    assign wbm_we_o    = r_we;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign wbm_sel_o   = r_sel;

endmodule

`default_nettype wire
